codon_framer: RTL and testbench

- Upstream stage of the codon-to-amino-acid translator (`aa[4:0]` from `codon[5:0]`).
- Takes a serial stream of 2-bit nucleotides with a valid/ready handshake and searches for the AUG start codon.
- Once AUG is found, it frames the following stream into 3-nucleotide codons and presents each codon on a valid/ready output until a stop codon or the length limit.
- Its `codon` output connects directly to the translator's `codon` input.

---
 rtl/codon_framer.sv | 128 ++++++++++++
 tb/tb_codon_framer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/codon_framer.sv
// Frames a 2-bit nucleotide stream into codons from an AUG start codon to a stop codon or the length limit.
// Latency: a codon is valid one cycle after its third nucleotide is accepted.
// Backpressure: nt_ready is low while a codon is pending; codon fields hold until codon_ready.
module codon_framer #(
  parameter int CNT_W      = 8,
  parameter int MAX_CODONS = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nt_valid,
  input  logic [1:0]       nt,
  output logic             nt_ready,
  output logic             codon_valid,
  output logic [5:0]       codon,
  input  logic             codon_ready,
  output logic             codon_first,
  output logic             codon_last,
  output logic             truncated,
  output logic [CNT_W-1:0] codon_count,
  output logic             in_orf
);

  localparam logic [5:0]       AUG   = 6'b100011;
  localparam logic [5:0]       UAA   = 6'b001010;
  localparam logic [5:0]       UAG   = 6'b001011;
  localparam logic [5:0]       UGA   = 6'b001110;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CODONS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic {SEARCH = 1'b0, TRANSLATE = 1'b1} state_t;

  state_t           state;
  // Only the two most recent nucleotides are kept; the incoming one completes the 3-nt window.
  logic [3:0]       window;
  logic [1:0]       fill;
  logic [1:0]       phase;
  logic [3:0]       acc;

  logic             nt_fire;
  logic             codon_fire;
  logic [5:0]       search_win;
  logic [5:0]       framed;
  logic [CNT_W-1:0] next_count;
  logic             is_stop;

  // Input side stalls whenever a codon is waiting; depends on registered state only.
  assign nt_ready   = ~codon_valid;
  assign nt_fire    = nt_valid & nt_ready;
  assign codon_fire = codon_valid & codon_ready;
  assign search_win = {window, nt};
  assign framed     = {acc, nt};
  assign next_count = codon_count + ONE_C;
  assign is_stop    = (framed == UAA) || (framed == UAG) || (framed == UGA);

  // Search / translate state machine with registered codon outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      window      <= 4'd0;
      fill        <= 2'd0;
      phase       <= 2'd0;
      acc         <= 4'd0;
      codon_valid <= 1'b0;
      codon       <= 6'd0;
      codon_first <= 1'b0;
      codon_last  <= 1'b0;
      truncated   <= 1'b0;
      codon_count <= '0;
      in_orf      <= 1'b0;
    end else begin
      // Codon consumed; the final codon of an ORF sends the block back to a clean search.
      if (codon_fire) begin
        codon_valid <= 1'b0;
        if (codon_last) begin
          state  <= SEARCH;
          window <= 4'd0;
          fill   <= 2'd0;
          in_orf <= 1'b0;
        end
      end

      // nt_fire and codon_fire never coincide because nt_ready is ~codon_valid.
      if (nt_fire) begin
        case (state)
          SEARCH: begin
            window <= search_win[3:0];
            if (fill != 2'd3) fill <= fill + 2'd1;
            if (search_win == AUG && fill >= 2'd2) begin
              codon       <= AUG;
              codon_valid <= 1'b1;
              codon_first <= 1'b1;
              codon_last  <= 1'b0;
              truncated   <= 1'b0;
              codon_count <= ONE_C;
              phase       <= 2'd0;
              in_orf      <= 1'b1;
              state       <= TRANSLATE;
            end
          end
          TRANSLATE: begin
            if (phase == 2'd2) begin
              codon       <= framed;
              codon_valid <= 1'b1;
              codon_first <= 1'b0;
              codon_count <= next_count;
              phase       <= 2'd0;
              if (is_stop) begin
                codon_last <= 1'b1;
                truncated  <= 1'b0;
              end else if (next_count == MAX_C) begin
                codon_last <= 1'b1;
                truncated  <= 1'b1;
              end else begin
                codon_last <= 1'b0;
                truncated  <= 1'b0;
              end
            end else begin
              acc   <= {acc[1:0], nt};
              phase <= phase + 2'd1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codon_framer.sv
// Scoreboard bench for codon_framer built with MAX_CODONS=4 so truncation is reachable.
// Stimulus pushes expected codons; a monitor pops them on every output handshake.
module tb_codon_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       nt_valid = 1'b0;
  logic [1:0] nt = 2'b00;
  logic       codon_ready = 1'b1;
  logic       nt_ready;
  logic       codon_valid;
  logic [5:0] codon;
  logic       codon_first;
  logic       codon_last;
  logic       truncated;
  logic [7:0] codon_count;
  logic       in_orf;

  typedef struct packed {
    logic [5:0] c;
    logic       f;
    logic       l;
    logic       t;
    logic [7:0] n;
  } exp_t;

  exp_t q[$];
  exp_t act_e;
  exp_t exp_e;
  int   checks = 0;
  int   errors = 0;

  codon_framer #(.CNT_W(8), .MAX_CODONS(4)) dut (
    .clk(clk), .rst_n(rst_n), .nt_valid(nt_valid), .nt(nt), .nt_ready(nt_ready),
    .codon_valid(codon_valid), .codon(codon), .codon_ready(codon_ready),
    .codon_first(codon_first), .codon_last(codon_last), .truncated(truncated),
    .codon_count(codon_count), .in_orf(in_orf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_codon(input logic [5:0] c, input logic f, input logic l,
                              input logic t, input logic [7:0] n);
    exp_t e;
    e = '{c: c, f: f, l: l, t: t, n: n};
    q.push_back(e);
  endtask

  // Monitor: compare each consumed codon against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (rst_n && codon_valid && codon_ready) begin
      act_e = '{c: codon, f: codon_first, l: codon_last, t: truncated, n: codon_count};
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_codon: got %0h expected none", act_e);
      end else begin
        exp_e = q.pop_front();
        chk("codon_out{codon,first,last,trunc,count}", 32'(act_e), 32'(exp_e));
      end
    end
  end

  // Offer one nucleotide from a negedge until it is accepted; returns on a negedge.
  task automatic send(input logic [1:0] n);
    logic acc_now;
    nt_valid = 1'b1;
    nt       = n;
    for (int t = 0; t < 100; t++) begin
      acc_now = nt_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc_now) begin
        nt_valid = 1'b0;
        return;
      end
    end
    chk("nt_accept_timeout", 32'd0, 32'd1);
    nt_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "U":     send(2'b00);
        "C":     send(2'b01);
        "A":     send(2'b10);
        default: send(2'b11);
      endcase
    end
  endtask

  // Wait for the last codon to drain, then the block must be back in SEARCH.
  task automatic wait_idle(input string name);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!codon_valid) break;
    end
    chk({name, "_drained"}, 32'(codon_valid), 32'd0);
    chk({name, "_in_orf"}, 32'(in_orf), 32'd0);
    chk({name, "_queue"}, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_codon_valid"}, 32'(codon_valid), 32'd0);
    chk({name, "_codon"}, 32'(codon), 32'd0);
    chk({name, "_first"}, 32'(codon_first), 32'd0);
    chk({name, "_last"}, 32'(codon_last), 32'd0);
    chk({name, "_truncated"}, 32'(truncated), 32'd0);
    chk({name, "_count"}, 32'(codon_count), 32'd0);
    chk({name, "_in_orf"}, 32'(in_orf), 32'd0);
    chk({name, "_nt_ready"}, 32'(nt_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_reset_state("reset");
    #9 rst_n = 1'b1;
    @(negedge clk);

    // Basic ORF: C then AUG GCU UAA.
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_codon(6'b110100, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_codon(6'b001010, 1'b0, 1'b1, 1'b0, 8'd3);
    send_str("CAUGGCUUAA");
    wait_idle("basic");

    // Backpressure on GCU for 5 cycles while a further nucleotide is offered.
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_codon(6'b110100, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_codon(6'b001010, 1'b0, 1'b1, 1'b0, 8'd3);
    send_str("CAUGGC");
    codon_ready = 1'b0;
    send_str("U");
    nt_valid = 1'b1;
    nt       = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(codon_valid), 32'd1);
      chk("stall_codon", 32'(codon), 32'b110100);
      chk("stall_nt_ready", 32'(nt_ready), 32'd0);
      chk("stall_count", 32'(codon_count), 32'd2);
      @(negedge clk);
    end
    codon_ready = 1'b1;
    send_str("UAA");
    wait_idle("backpressure");

    // Stop codon ignored in SEARCH; overlapping A,A,U,G detects AUG.
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_codon(6'b001011, 1'b0, 1'b1, 1'b0, 8'd2);
    send_str("UAAAAUGUAG");
    wait_idle("search");

    // Truncation at MAX_CODONS=4; inner AUG is an ordinary codon.
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_codon(6'b110100, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_codon(6'b100011, 1'b0, 1'b0, 1'b0, 8'd3);
    expect_codon(6'b010101, 1'b0, 1'b1, 1'b1, 8'd4);
    send_str("AUGGCUAUGCCC");
    wait_idle("truncate");

    // Reset after AUG plus two nucleotides, asserted away from any edge.
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    send_str("AUGGC");
    chk("pre_reset_in_orf", 32'(in_orf), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    chk("midreset_queue", 32'(q.size()), 32'd0);
    q.delete();
    #4 rst_n = 1'b1;
    @(negedge clk);
    send_str("GA");
    @(negedge clk);
    chk("post_reset_no_codon", 32'(codon_valid), 32'd0);
    chk("post_reset_no_orf", 32'(in_orf), 32'd0);

    // Two ORFs back to back: AUG UGA, then AUG CCC UAG.
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_codon(6'b001110, 1'b0, 1'b1, 1'b0, 8'd2);
    expect_codon(6'b100011, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_codon(6'b010101, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_codon(6'b001011, 1'b0, 1'b1, 1'b0, 8'd3);
    send_str("AUGUGAAUGCCCUAG");
    wait_idle("back2back");
    chk("final_count_held", 32'(codon_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
